// File: rtl/bus_arbiter_pkg.sv
// Shared types for the ibus/dbus to memory arbiter.
// FSM state, owner, core-side bus bundles and latched memory request.
package bus_arbiter_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    IBUS,
    DBUS
  } arb_owner_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [2:0]      size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    logic [2:0]      size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } mem_req_t;

  function automatic logic [31:0] ibus_slice(
    input logic [XLEN-1:0] d,
    input logic            hi
  );
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Grant decision: dbus first unless ibus has starved for LIMIT grants.
// Ports: ivalid/dvalid/cnt in; grant_i/grant_d/cnt_next out.
module bus_arbiter_picker #(
  parameter int LIMIT = 4,
  parameter int CW    = 3
) (
  input  logic          ivalid,
  input  logic          dvalid,
  input  logic [CW-1:0] cnt,
  output logic          grant_i,
  output logic          grant_d,
  output logic [CW-1:0] cnt_next
);

  logic starved;
  logic sat;

  assign starved = ivalid && (cnt == CW'(LIMIT));
  assign sat     = (cnt == CW'(LIMIT));
  assign grant_d = dvalid && !starved;
  assign grant_i = ivalid && !grant_d;

  always_comb begin
    cnt_next = cnt;
    unique case (1'b1)
      grant_i:           cnt_next = '0;
      grant_d && ivalid: cnt_next = sat ? cnt : cnt + 1'b1;
      default:           cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises core ibus/dbus requests onto one memory channel.
// Ports: clk, reset(async low), ireq/iresp, dreq/dresp, mreq_*, mresp_*.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  ibus_req_t         ireq,
  output ibus_resp_t        iresp,
  input  dbus_req_t         dreq,
  output dbus_resp_t        dresp,
  output logic              mreq_valid,
  input  logic              mreq_ready,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic              mreq_write,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_valid,
  input  logic [DATA_W-1:0] mresp_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state;
  arb_state_t      state_d;
  arb_owner_t      owner;
  mem_req_t        req_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [XLEN-1:0] rdata_q;
  logic            iaok_q;
  logic            daok_q;
  logic            grant_i;
  logic            grant_d;
  logic            idone;
  logic            ddone;

  bus_arbiter_picker #(
    .LIMIT(STARVE_LIMIT),
    .CW   (CW)
  ) u_arb_picker (
    .ivalid  (ireq.valid),
    .dvalid  (dreq.valid),
    .cnt     (cnt),
    .grant_i (grant_i),
    .grant_d (grant_d),
    .cnt_next(cnt_next)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (grant_i || grant_d) state_d = REQ;
      REQ:
        if (mreq_ready)
          state_d = mresp_valid ? DONE : WAIT;
      WAIT: if (mresp_valid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= NONE;
      cnt        <= '0;
      req_q      <= '0;
      mreq_valid <= 1'b0;
      rdata_q    <= '0;
      iaok_q     <= 1'b0;
      daok_q     <= 1'b0;
    end else begin
      state  <= state_d;
      iaok_q <= 1'b0;
      daok_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= cnt_next;
          if (grant_d) begin
            owner      <= DBUS;
            mreq_valid <= 1'b1;
            req_q      <= '{write:  |dreq.strobe,
                            addr:   dreq.addr,
                            size:   dreq.size,
                            strobe: dreq.strobe,
                            data:   dreq.data};
          end else if (grant_i) begin
            owner      <= IBUS;
            mreq_valid <= 1'b1;
            req_q      <= '{write:  1'b0,
                            addr:   ireq.addr,
                            size:   3'd2,
                            strobe: 8'h00,
                            data:   '0};
          end
        end
        REQ: begin
          if (mreq_ready) begin
            mreq_valid <= 1'b0;
            iaok_q     <= (owner == IBUS);
            daok_q     <= (owner == DBUS);
            if (mresp_valid)
              rdata_q <= mresp_data[XLEN-1:0];
          end
        end
        WAIT: begin
          if (mresp_valid)
            rdata_q <= mresp_data[XLEN-1:0];
        end
        DONE: owner <= NONE;
        default: owner <= NONE;
      endcase
    end
  end

  // data_ok is withheld if the owner dropped valid early
  assign idone = (state == DONE) && (owner == IBUS) && ireq.valid;
  assign ddone = (state == DONE) && (owner == DBUS) && dreq.valid;

  assign iresp = '{addr_ok: iaok_q,
                   data_ok: idone,
                   data:    idone ? ibus_slice(rdata_q, req_q.addr[2])
                                  : 32'h0};
  assign dresp = '{addr_ok: daok_q,
                   data_ok: ddone,
                   data:    ddone ? rdata_q : '0};

  assign mreq_addr   = req_q.addr[ADDR_W-1:0];
  assign mreq_write  = req_q.write;
  assign mreq_size   = req_q.size;
  assign mreq_strobe = req_q.strobe;
  assign mreq_data   = req_q.data[DATA_W-1:0];

  ibus_hold: assert property (@(posedge clk) disable iff (!reset)
    (state != IDLE && owner == IBUS) |-> ireq.valid);
  dbus_hold: assert property (@(posedge clk) disable iff (!reset)
    (state != IDLE && owner == DBUS) |-> dreq.valid);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter.
// Hand-computed expectations, immediate assertions per check.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        mreq_valid;
  logic        mreq_ready;
  logic [63:0] mreq_addr;
  logic        mreq_write;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_valid;
  logic [63:0] mresp_data;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] IA1 = 64'h8000_0004;
  localparam logic [63:0] IA0 = 64'h8000_0000;
  localparam logic [63:0] DA  = 64'h8000_0100;
  localparam logic [63:0] WA  = 64'h8000_0010;
  localparam logic [63:0] WD  = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] M1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] M2  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] M3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M5  = 64'h5555_6666_7777_8888;

  bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .ireq       (ireq),
    .iresp      (iresp),
    .dreq       (dreq),
    .dresp      (dresp),
    .mreq_valid (mreq_valid),
    .mreq_ready (mreq_ready),
    .mreq_addr  (mreq_addr),
    .mreq_write (mreq_write),
    .mreq_size  (mreq_size),
    .mreq_strobe(mreq_strobe),
    .mreq_data  (mreq_data),
    .mresp_valid(mresp_valid),
    .mresp_data (mresp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mreq_valid"}, 64'(mreq_valid), 64'd0);
    chk({tag, " mreq_addr"}, mreq_addr, 64'd0);
    chk({tag, " mreq_wr"}, 64'(mreq_write), 64'd0);
    chk({tag, " mreq_size"}, 64'(mreq_size), 64'd0);
    chk({tag, " mreq_strb"}, 64'(mreq_strobe), 64'd0);
    chk({tag, " mreq_data"}, mreq_data, 64'd0);
    chk({tag, " iresp"}, 64'(iresp), 64'd0);
    chk({tag, " dresp_ok"}, 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    chk({tag, " dresp_d"}, dresp.data, 64'd0);
  endtask

  initial begin
    logic [63:0] g[$];
    int ni;
    int nd;
    ireq = '0;
    dreq = '0;
    mreq_ready = 1'b0;
    mresp_valid = 1'b0;
    mresp_data = '0;

    #2;
    chk_zero("rst");
    step();
    reset = 1'b1;
    step();

    // 1: ibus alone, response one cycle after accept
    ireq = '{valid: 1'b1, addr: IA1};
    mreq_ready = 1'b1;
    step();
    chk("t1 mreq_valid", 64'(mreq_valid), 64'd1);
    chk("t1 mreq_addr", mreq_addr, IA1);
    chk("t1 mreq_wr", 64'(mreq_write), 64'd0);
    chk("t1 mreq_strb", 64'(mreq_strobe), 64'd0);
    chk("t1 aok early", 64'(iresp.addr_ok), 64'd0);
    step();
    chk("t1 aok", 64'(iresp.addr_ok), 64'd1);
    chk("t1 mreq_valid lo", 64'(mreq_valid), 64'd0);
    chk("t1 dok early", 64'(iresp.data_ok), 64'd0);
    mresp_valid = 1'b1;
    mresp_data = M1;
    step();
    mresp_valid = 1'b0;
    chk("t1 dok", 64'(iresp.data_ok), 64'd1);
    chk("t1 data", 64'(iresp.data), 64'h1111_2222);
    chk("t1 aok drop", 64'(iresp.addr_ok), 64'd0);
    chk("t1 no dresp", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    step();
    ireq.valid = 1'b0;
    chk("t1 dok pulse", 64'(iresp.data_ok), 64'd0);
    step();

    // 2: both together, dbus read first then ibus
    ireq = '{valid: 1'b1, addr: IA0};
    dreq = '{valid: 1'b1, addr: DA, size: 3'd3,
             strobe: 8'h00, data: 64'h0};
    mreq_ready = 1'b1;
    mresp_valid = 1'b1;
    mresp_data = M2;
    step();
    chk("t2 first addr", mreq_addr, DA);
    chk("t2 first rd", 64'(mreq_write), 64'd0);
    chk("t2 size", 64'(mreq_size), 64'd3);
    step();
    chk("t2 d aok", 64'(dresp.addr_ok), 64'd1);
    chk("t2 d dok", 64'(dresp.data_ok), 64'd1);
    chk("t2 d data", dresp.data, M2);
    chk("t2 i quiet", 64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
    mresp_data = M3;
    step();
    dreq.valid = 1'b0;
    chk("t2 gap", 64'(mreq_valid), 64'd0);
    chk("t2 d dok pulse", 64'(dresp.data_ok), 64'd0);
    step();
    chk("t2 second valid", 64'(mreq_valid), 64'd1);
    chk("t2 second addr", mreq_addr, IA0);
    chk("t2 second size", 64'(mreq_size), 64'd2);
    step();
    chk("t2 i dok", 64'(iresp.data_ok), 64'd1);
    chk("t2 i data", 64'(iresp.data), 64'h89AB_CDEF);
    chk("t2 d quiet", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    step();
    ireq.valid = 1'b0;
    step();

    // 3: dbus held, ibus pending: four dbus grants then ibus
    ireq = '{valid: 1'b1, addr: IA0};
    dreq = '{valid: 1'b1, addr: DA, size: 3'd3,
             strobe: 8'h00, data: 64'h0};
    ni = 0;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (mreq_valid) g.push_back(mreq_addr);
      if (iresp.data_ok) ni++;
      if (dresp.data_ok) nd++;
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    chk("t3 grants", 64'(g.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t3 grant%0d", k),
          (k < g.size()) ? g[k] : 64'hx,
          (k < 4) ? DA : IA0);
    chk("t3 i dok cnt", 64'(ni), 64'd1);
    chk("t3 d dok cnt", 64'(nd), 64'd4);
    step();
    step();

    // 4: dbus write with three stall cycles
    mreq_ready = 1'b0;
    mresp_valid = 1'b0;
    dreq = '{valid: 1'b1, addr: WA, size: 3'd3,
             strobe: 8'hF0, data: WD};
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4 valid%0d", k), 64'(mreq_valid), 64'd1);
      chk($sformatf("t4 addr%0d", k), mreq_addr, WA);
      chk($sformatf("t4 wr%0d", k), 64'(mreq_write), 64'd1);
      chk($sformatf("t4 strb%0d", k), 64'(mreq_strobe), 64'hF0);
      chk($sformatf("t4 data%0d", k), mreq_data, WD);
      chk($sformatf("t4 aok%0d", k), 64'(dresp.addr_ok), 64'd0);
      if (k < 2) step();
    end
    mreq_ready = 1'b1;
    step();
    mreq_ready = 1'b0;
    chk("t4 aok", 64'(dresp.addr_ok), 64'd1);
    chk("t4 dok early", 64'(dresp.data_ok), 64'd0);
    mresp_valid = 1'b1;
    mresp_data = 64'h0;
    step();
    mresp_valid = 1'b0;
    chk("t4 dok", 64'(dresp.data_ok), 64'd1);
    step();
    dreq.valid = 1'b0;
    chk("t4 dok pulse", 64'(dresp.data_ok), 64'd0);
    step();

    // 5: accept and response in the same cycle
    ireq = '{valid: 1'b1, addr: IA0};
    mreq_ready = 1'b1;
    mresp_valid = 1'b1;
    mresp_data = M5;
    step();
    chk("t5 req", 64'(mreq_valid), 64'd1);
    step();
    chk("t5 aok+dok", 64'({iresp.addr_ok, iresp.data_ok}), 64'd3);
    chk("t5 data", 64'(iresp.data), 64'h7777_8888);
    step();
    ireq.valid = 1'b0;
    chk("t5 back idle", 64'({mreq_valid, iresp.addr_ok, iresp.data_ok}),
        64'd0);
    step();
    chk("t5 no regrant", 64'(mreq_valid), 64'd0);

    // 6: reset while waiting for the response
    mresp_valid = 1'b0;
    dreq = '{valid: 1'b1, addr: DA, size: 3'd3,
             strobe: 8'h00, data: 64'h0};
    step();
    step();
    chk("t6 in wait", 64'(dresp.addr_ok), 64'd1);
    reset = 1'b0;
    #1;
    chk_zero("t6 async");
    dreq = '0;
    mresp_valid = 1'b1;
    mresp_data = M1;
    step();
    reset = 1'b1;
    step();
    chk("t6 no stale d", 64'(dresp.data_ok), 64'd0);
    chk("t6 no stale i", 64'(iresp.data_ok), 64'd0);
    step();
    chk_zero("t6 after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
